uart_tx_arbiter: RTL

Round-robin transmit scheduler that shares one UART serial output among several byte-stream requesters, such as SHA-256 digest dump and status/debug sources. It takes the 16x oversampling tick from the existing baud rate generator. One requester is granted per frame, and the byte is serialized as start, data LSB-first, optional parity, and stop on `tx`. The block sits between the hashing core's result interfaces and the board UART pin.

---
 rtl/uart_tx_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin scheduler sharing one UART tx line among NREQ byte
//            sources; one granted byte per frame, 16x oversampled bit timing.
//            Define UART_TX_ARB_PARITY_EN to insert an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                i_s_tick,
    input  logic [NREQ-1:0]                     i_req_valid,
    input  logic [NREQ*DBIT-1:0]                i_req_data,
    output logic [NREQ-1:0]                     o_req_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] o_grant_id,
    output logic                                o_busy,
    output logic                                o_tx
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_ARB_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    state_t             r_state;
    logic [TW-1:0]      r_tick;
    logic [BW-1:0]      r_bit;
    logic [DBIT-1:0]    r_shreg;
    logic [LW-1:0]      r_last;
    logic [LW-1:0]      r_grant;
    logic               r_busy;
    logic               r_tx;
`ifdef UART_TX_ARB_PARITY_EN
    logic               r_par;
`endif

    logic               w_found;
    logic [LW-1:0]      w_winner;
    logic [NREQ-1:0]    w_ready;
    logic               w_bit_end;

    assign w_bit_end = i_s_tick && (r_tick == TW'(15));

    // Search starts one past the last winner so every source gets a turn.
    always_comb begin : p_rr
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(r_last) + k) % NREQ;
            if (!w_found && i_req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = LW'(idx);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (reset_n && (r_state == S_IDLE) && w_found) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_last  <= LW'(NREQ - 1);
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_shreg <= i_req_data[int'(w_winner)*DBIT +: DBIT];
                        r_last  <= w_winner;
                        r_grant <= w_winner;
                        r_tick  <= '0;
                        r_busy  <= 1'b1;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
`ifdef UART_TX_ARB_PARITY_EN
                        r_par   <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shreg[0];
                        r_state <= S_DATA;
                    end else if (i_s_tick) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_tick  <= '0;
                        r_shreg <= r_shreg >> 1;
`ifdef UART_TX_ARB_PARITY_EN
                        r_par   <= r_par ^ r_shreg[0];
`endif
                        if (r_bit == BW'(DBIT - 1)) begin
`ifdef UART_TX_ARB_PARITY_EN
                            r_tx    <= r_par ^ r_shreg[0];
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + BW'(1);
                            r_tx  <= r_shreg[1];
                        end
                    end else if (i_s_tick) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
`ifdef UART_TX_ARB_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_tick  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else if (i_s_tick) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (i_s_tick && (r_tick == TW'(SB_TICK - 1))) begin
                        r_tick  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (i_s_tick) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready = w_ready;
    assign o_grant_id  = r_grant;
    assign o_busy      = r_busy;
    assign o_tx        = r_tx;

endmodule
`default_nettype wire
